// File: rtl/shift_seq_ctrl.sv
// rtl/shift_seq_ctrl.sv - iterative STEP-bit-per-cycle shift sequencer with pipeline stall
//
// Purpose: replaces a single-cycle barrel shifter. The shift is performed over
// ceil(sa/STEP) cycles while the pipeline is stalled.
//
// Optional feature macro: SHIFT_ROTR_EN
//   When defined, op=10 rotates right. When undefined, op=10 behaves as SRL.
//
// Ports:
//   clk     rising-edge clock
//   rst     synchronous active-high reset
//   start   shift request, sampled only in IDLE
//   op      00 SLL, 01 SRL, 11 SRA, 10 ROTR/SRL
//   src     operand to shift
//   sa      shift amount
//   flush   abort the current operation
//   stall   combinational pipeline hold
//   busy    FSM not in IDLE
//   done    one-cycle pulse when result is valid
//   result  shifted value, held until the next completion
module shift_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int SA_W  = 5,
  parameter int STEP  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src,
  input  logic [SA_W-1:0]  sa,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_SHIFT = 2'b01;
  localparam logic [1:0] S_DONE  = 2'b10;

  localparam logic [SA_W:0] STEP_N  = (SA_W+1)'(STEP);
  localparam logic [SA_W:0] WIDTH_N = (SA_W+1)'(WIDTH);

  logic [1:0]       state;
  logic [WIDTH-1:0] acc;
  logic [1:0]       op_q;
  logic [SA_W-1:0]  rem;

  logic [SA_W:0]    n;        // bits shifted this cycle: min(STEP, rem)
  logic [SA_W:0]    rot_l;    // complementary left shift for the rotate
  logic [WIDTH-1:0] stepped;  // acc after this cycle's partial shift

  always_comb begin
    n       = ({1'b0, rem} >= STEP_N) ? STEP_N : {1'b0, rem};
    rot_l   = WIDTH_N - n;
    stepped = acc;
    case (op_q)
      2'b00: stepped = acc << n;
      2'b01: stepped = acc >> n;
      2'b11: stepped = $unsigned($signed(acc) >>> n);
`ifdef SHIFT_ROTR_EN
      // n is never 0 in SHIFT, so rot_l stays below WIDTH.
      2'b10: stepped = (acc >> n) | (acc << rot_l);
`else
      2'b10: stepped = acc >> n;
`endif
      default: stepped = acc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      acc    <= '0;
      op_q   <= 2'b00;
      rem    <= '0;
      done   <= 1'b0;
      result <= '0;
    end else if (flush) begin
      // Abort without pulsing done; result keeps its last completed value.
      state <= S_IDLE;
      done  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            acc  <= src;
            op_q <= op;
            rem  <= sa;
            if (sa == '0) begin
              state  <= S_DONE;
              done   <= 1'b1;
              result <= src;
            end else begin
              state <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          acc <= stepped;
          rem <= rem - n[SA_W-1:0];
          // Final step: capture the result on entry to DONE.
          if (n == {1'b0, rem}) begin
            state  <= S_DONE;
            done   <= 1'b1;
            result <= stepped;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy  = (state != S_IDLE);
  assign stall = !rst && (((state == S_IDLE) && start) || (state == S_SHIFT));

endmodule
